// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, FSM encoding and
// default frame geometry.
package spi_pkg;

  localparam int DEF_FRAME_W = 10;
  localparam int DEF_DATA_W  = 8;
  localparam int CNT_W       = 4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_TURN    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  // Terminal-count load value for a phase lasting n cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// TX parallel-in/serial-out and RX serial-in/parallel-out registers sharing one
// 4-bit down counter whose done flag marks the last cycle of each phase.
module spi_frame_shifter
  import spi_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_load_i,
  input  logic [FRAME_W-1:0] tx_frame_i,
  input  logic               tx_shift_i,
  input  logic               rx_shift_i,
  input  logic               rx_bit_i,
  input  logic               cnt_load_i,
  input  logic [CNT_W-1:0]   cnt_val_i,
  input  logic               cnt_dec_i,
  output logic               tx_msb_o,
  output logic [DATA_W-1:0]  rx_next_o,
  output logic               cnt_done_o
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (tx_load_i) begin
      tx_q <= tx_frame_i;
    end else if (tx_shift_i) begin
      tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q <= '0;
    end else if (rx_shift_i) begin
      rx_q <= rx_next_o;
    end
  end

  // Holds at zero rather than wrapping if a decrement arrives at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_load_i) begin
      cnt_q <= cnt_val_i;
    end else if (cnt_dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tx_msb_o   = tx_q[FRAME_W-1];
  assign rx_next_o  = {rx_q[DATA_W-2:0], rx_bit_i};
  assign cnt_done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: accepts one command frame per handshake, shifts it out
// MSB-first and, for read-data commands, captures the slave's response byte.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a frame
// SHIFT   | SS_n low, frame bits on MOSI MSB-first
// TURN    | SS_n low, MOSI low, slave turnaround before read data
// CAPTURE | SS_n low, MISO sampled into RX register
// GAP     | SS_n high, minimum deselect time before next frame
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_TURN = 2,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_frame,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [CNT_W-1:0] LD_FRAME = cnt_load(FRAME_W);
  localparam logic [CNT_W-1:0] LD_TURN  = cnt_load(RD_TURN);
  localparam logic [CNT_W-1:0] LD_DATA  = cnt_load(DATA_W);
  localparam logic [CNT_W-1:0] LD_GAP   = cnt_load(GAP);

  state_e state_q, state_d;
  logic   is_rd_q, is_rd_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic   rd_valid_q;

  logic             tx_load, tx_shift, rx_shift;
  logic             cnt_load_en, cnt_dec, cnt_done;
  logic [CNT_W-1:0] cnt_val;
  logic             tx_msb;
  logic [DATA_W-1:0] rx_next;
  logic             rd_done;

  spi_frame_shifter #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_load_i  (tx_load),
    .tx_frame_i (cmd_frame),
    .tx_shift_i (tx_shift),
    .rx_shift_i (rx_shift),
    .rx_bit_i   (MISO),
    .cnt_load_i (cnt_load_en),
    .cnt_val_i  (cnt_val),
    .cnt_dec_i  (cnt_dec),
    .tx_msb_o   (tx_msb),
    .rx_next_o  (rx_next),
    .cnt_done_o (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_done;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    cnt_load_en = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    rd_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tx_load     = 1'b1;
          cnt_load_en = 1'b1;
          cnt_val     = LD_FRAME;
          is_rd_d     = (cmd_frame[FRAME_W-1 -: 2] == CMD_RD_DATA);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_done) begin
          cnt_load_en = 1'b1;
          if (is_rd_q) begin
            cnt_val = LD_TURN;
            state_d = S_TURN;
          end else begin
            cnt_val = LD_GAP;
            state_d = S_GAP;
          end
        end else begin
          tx_shift = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_done) begin
          cnt_load_en = 1'b1;
          cnt_val     = LD_DATA;
          state_d     = S_CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_CAPTURE: begin
        rx_shift = 1'b1;
        if (cnt_done) begin
          rd_done     = 1'b1;
          cnt_load_en = 1'b1;
          cnt_val     = LD_GAP;
          state_d     = S_GAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_done) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The final MISO bit is folded in directly so rd_data lands with rd_valid.
  assign rd_data_d = rd_done ? rx_next : rd_data_q;

  assign cmd_ready = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = !((state_q == S_SHIFT) || (state_q == S_TURN) || (state_q == S_CAPTURE));
  assign MOSI      = (state_q == S_SHIFT) && tx_msb;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
